// File: rtl/gate2_truth_checker.sv
// Sequences a 2-input gate through all four input vectors, samples its output after a
// settle delay and compares it against a parameterised truth table.
module gate2_truth_checker #(
    parameter logic [3:0]  EXPECTED      = 4'b0111,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_out,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam int unsigned CW = ($clog2(SETTLE_CYCLES + 1) < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic          miss;
    logic [2:0]    next_err;

    // pass must see the error count that includes the final sample
    always_comb begin
        miss     = (dut_out != EXPECTED[idx]);
        next_err = err_count + {2'b00, miss};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= SETTLE;
                        idx       <= '0;
                        cnt       <= '0;
                        dut_a     <= 1'b0;
                        dut_b     <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_vec  <= '0;
                    end
                end
                SETTLE: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        err_count <= next_err;
                        if (miss) fail_vec[idx] <= 1'b1;
                        if (idx != 2'd3) begin
                            idx            <= idx + 2'd1;
                            {dut_a, dut_b} <= idx + 2'd1;
                            cnt            <= '0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (next_err == 3'd0);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate2_truth_checker.sv
// Self-checking bench: two checker instances (NAND table S=2, AND table S=0) driving
// table-defined gate models, checked against a truth-table XOR reference model.
module tb_gate2_truth_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [3:0] gate0 = 4'b0111, gate1 = 4'b1000;
    logic       a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
    logic       out0, out1;
    logic [2:0] err0, err1;
    logic [3:0] fv0, fv1;
    int         checks = 0;
    int         errors = 0;

    assign out0 = gate0[{a0, b0}];
    assign out1 = gate1[{a1, b1}];

    always #5 clk = ~clk;

    gate2_truth_checker #(.EXPECTED(4'b0111), .SETTLE_CYCLES(2)) u_nand (
        .clk(clk), .rst(rst), .start(start0), .dut_out(out0), .dut_a(a0), .dut_b(b0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0));

    gate2_truth_checker #(.EXPECTED(4'b1000), .SETTLE_CYCLES(0)) u_and (
        .clk(clk), .rst(rst), .start(start1), .dut_out(out1), .dut_a(a1), .dut_b(b1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1));

    typedef struct {
        int         inst;
        logic [3:0] gate;
        logic [3:0] exp_fail;
        logic [2:0] exp_err;
        logic       exp_pass;
        string      name;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] snap(input int inst);
        if (inst == 0) return {a0, b0, busy0, done0, pass0, err0, fv0, 2'b00};
        return {a1, b1, busy1, done1, pass1, err1, fv1, 2'b00};
    endfunction

    task automatic set_start(input int inst, input logic v);
        if (inst == 0) start0 = v; else start1 = v;
    endtask

    // Full run with timing checks; pulse_at>0 re-asserts start mid-run to prove it is ignored.
    task automatic run(input int inst, input logic [3:0] g, input int pulse_at, input string tag);
        logic [3:0]  expect_tbl;
        logic [3:0]  m_fail;
        int          s, j;
        logic [13:0] v;
        expect_tbl = (inst == 0) ? 4'b0111 : 4'b1000;
        s          = (inst == 0) ? 2 : 0;
        m_fail     = g ^ expect_tbl;
        @(negedge clk);
        if (inst == 0) gate0 = g; else gate1 = g;
        set_start(inst, 1'b1);
        @(posedge clk); #1;
        set_start(inst, 1'b0);
        v = snap(inst);
        check({tag, "_start_state"}, {2'b0, v[13:8]}, 8'b0000_1000);
        check({tag, "_start_res"}, {1'b0, v[7:1]}, 8'h00);
        for (j = 1; j <= 60; j++) begin
            @(posedge clk); #1;
            set_start(inst, 1'b0);
            v = snap(inst);
            if (v[10]) break;
            check({tag, "_vec"}, {6'b0, v[13:12]}, 8'(j / (s + 1)));
            if (j == pulse_at) set_start(inst, 1'b1);
        end
        check({tag, "_latency"}, 8'(j), 8'(4 * (s + 1)));
        check({tag, "_fail_vec"}, {4'b0, v[5:2]}, {4'b0, m_fail});
        check({tag, "_err_count"}, {5'b0, v[8:6]}, 8'($countones(m_fail)));
        check({tag, "_pass"}, {7'b0, v[9]}, {7'b0, (m_fail == 4'b0)});
        check({tag, "_end_ab_busy"}, {5'b0, v[13:11]}, 8'b110);
    endtask

    initial begin
        tbl[0] = '{0, 4'b0111, 4'b0000, 3'd0, 1'b1, "nand"};
        tbl[1] = '{0, 4'b1111, 4'b1000, 3'd1, 1'b0, "tied1"};
        tbl[2] = '{0, 4'b0000, 4'b0111, 3'd3, 1'b0, "tied0"};
        tbl[3] = '{0, 4'b1000, 4'b1111, 3'd4, 1'b0, "and_vs_nand"};
        tbl[4] = '{1, 4'b1000, 4'b0000, 3'd0, 1'b1, "and_vs_and"};

        #12;
        check("reset_nand", {2'b0, snap(0)[13:8]}, 8'h00);
        check("reset_and", {2'b0, snap(1)[13:8]}, 8'h00);
        check("reset_res", {snap(0)[5:2], snap(1)[5:2]}, 8'h00);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            logic [13:0] v;
            run(tbl[i].inst, tbl[i].gate, 0, tbl[i].name);
            v = snap(tbl[i].inst);
            check({tbl[i].name, "_tbl_fail"}, {4'b0, v[5:2]}, {4'b0, tbl[i].exp_fail});
            check({tbl[i].name, "_tbl_err"}, {5'b0, v[8:6]}, {5'b0, tbl[i].exp_err});
            check({tbl[i].name, "_tbl_pass"}, {7'b0, v[9]}, {7'b0, tbl[i].exp_pass});
        end

        // start mid-run is ignored; done still 12 cycles after the real start
        run(0, 4'b0111, 4, "start_busy");

        // async reset mid-run clears everything before the next edge
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_async_state", {2'b0, snap(0)[13:8]}, 8'h00);
        check("rst_async_res", {4'b0, snap(0)[5:2]}, 8'h00);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stays_idle", {2'b0, snap(0)[13:8]}, 8'h00);
        run(0, 4'b0111, 0, "after_rst");

        // failing run, then restart from DONE clears results and passes
        run(0, 4'b0000, 0, "fail_then");
        run(0, 4'b0111, 0, "restart_done");

        // start held high: a new run begins on the first edge in DONE
        @(negedge clk); gate1 = 4'b1000; start1 = 1'b1;
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (done1) break;
            end
            check("held_done_seen", {7'b0, done1}, 8'd1);
            @(posedge clk); #1;
            check("held_restart", {6'b0, busy1, done1}, 8'b10);
            start1 = 1'b0;
            for (k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (done1) break;
            end
            check("held_second_pass", {6'b0, done1, pass1}, 8'b11);
        end

        for (int i = 0; i < 16; i++) begin
            run(i % 2, 4'($urandom_range(0, 15)), 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule
